// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU result capture, writeback decode, FIFO buffering and overflow traps
module alu_wb_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_result,
    input  logic [2:0]       in_flags,
    input  logic             flush,
    input  logic             wb_ready,
    output logic             wb_valid,
    output logic             wb_en,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic             ovf_exc,
    output logic [CNT_W-1:0] exc_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    // Entry layout: {trap, wb_en, dest[4:0], result[31:0]}
    localparam int EW = 39;

    logic [5:0]    op;
    logic [5:0]    fn;
    logic          r_writer;
    logic          i_writer;
    logic          dec_trap;
    logic          dec_en;
    logic [4:0]    dest;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;
    logic          empty;
    logic          full_nxt;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;
    logic          head_trap;
    logic          unused_bits;

    assign op = in_instr[31:26];
    assign fn = in_instr[5:0];

    // Only opcode/funct and the two register fields matter; flags[1:0] are not stored
    assign unused_bits = ^{in_instr[25:21], in_instr[10:6], in_flags[1:0]};

    // Decode destination, write enable and signed-overflow trap of the incoming entry
    always_comb begin
        r_writer = 1'b0;
        i_writer = 1'b0;
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: r_writer = 1'b1;
                default:                           r_writer = 1'b0;
            endcase
        end
        case (op)
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: i_writer = 1'b1;
            default:                    i_writer = 1'b0;
        endcase
        dest     = r_writer ? in_instr[15:11] : in_instr[20:16];
        // Only add, sub and addi trap; their unsigned variants never do
        dec_trap = in_flags[2] & ((op == 6'h08) |
                                  ((op == 6'h00) & ((fn == 6'h20) | (fn == 6'h22))));
        dec_en   = (r_writer | i_writer) & ~dec_trap & (dest != 5'd0);
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign wb_valid  = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = wb_valid & wb_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_trap = head[38];

    // Head fields read as zero while the FIFO is empty so reset/flush leave clean outputs
    assign wb_en   = wb_valid & head[37];
    assign wb_addr = wb_valid ? head[36:32] : 5'd0;
    assign wb_data = wb_valid ? head[31:0]  : 32'd0;

    // Next pointer values; flush wins over any same-cycle push or pop
    always_comb begin
        wr_nxt = flush ? '0 : wr_ptr + PW'(push);
        rd_nxt = flush ? '0 : rd_ptr + PW'(pop);
        full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end

    // Pointer state and the registered ready, which always tracks !full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b1;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            in_ready <= ~full_nxt;
        end
    end

    // Entry storage; a write discarded by flush is harmless since pointers return to zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {dec_trap, dec_en, dest, in_result};
        end
    end

    // Exception pulse and saturating counter on pop of a trapping entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_exc   <= 1'b0;
            exc_count <= '0;
        end else begin
            ovf_exc <= pop & head_trap & ~flush;
            if (pop && head_trap && !flush && (exc_count != {CNT_W{1'b1}})) begin
                exc_count <= exc_count + 1'b1;
            end
        end
    end
endmodule
